// File: rtl/ps2_pkg.sv
// Shared PS/2 decoder constants: scan codes, prefix FSM states, held-key bit map.
package ps2_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CODE_W = 8;
    localparam int unsigned HELD_W = 11;

    localparam logic [CODE_W-1:0] SC_E0 = 8'hE0;
    localparam logic [CODE_W-1:0] SC_F0 = 8'hF0;

    // Protocol/controller bytes that never represent a key.
    localparam logic [CODE_W-1:0] SC_ERR0 = 8'h00;
    localparam logic [CODE_W-1:0] SC_BAT  = 8'hAA;
    localparam logic [CODE_W-1:0] SC_ECHO = 8'hEE;
    localparam logic [CODE_W-1:0] SC_ACK  = 8'hFA;
    localparam logic [CODE_W-1:0] SC_RSND = 8'hFE;
    localparam logic [CODE_W-1:0] SC_ERR1 = 8'hFF;
    localparam logic [CODE_W-1:0] SC_E1   = 8'hE1;

    localparam logic [CODE_W-1:0] SC_UP    = 8'h75;
    localparam logic [CODE_W-1:0] SC_DOWN  = 8'h72;
    localparam logic [CODE_W-1:0] SC_LEFT  = 8'h6B;
    localparam logic [CODE_W-1:0] SC_RIGHT = 8'h74;
    localparam logic [CODE_W-1:0] SC_W     = 8'h1D;
    localparam logic [CODE_W-1:0] SC_S     = 8'h1B;
    localparam logic [CODE_W-1:0] SC_A     = 8'h1C;
    localparam logic [CODE_W-1:0] SC_D     = 8'h23;
    localparam logic [CODE_W-1:0] SC_SPACE = 8'h29;
    localparam logic [CODE_W-1:0] SC_ENTER = 8'h5A;
    localparam logic [CODE_W-1:0] SC_ESC   = 8'h76;

    typedef logic [1:0] prefix_t;
    localparam prefix_t ST_IDLE    = 2'd0;
    localparam prefix_t ST_EXT     = 2'd1;
    localparam prefix_t ST_BRK     = 2'd2;
    localparam prefix_t ST_EXT_BRK = 2'd3;

    localparam int unsigned HB_UP    = 0;
    localparam int unsigned HB_DOWN  = 1;
    localparam int unsigned HB_LEFT  = 2;
    localparam int unsigned HB_RIGHT = 3;
    localparam int unsigned HB_W     = 4;
    localparam int unsigned HB_S     = 5;
    localparam int unsigned HB_A     = 6;
    localparam int unsigned HB_D     = 7;
    localparam int unsigned HB_SPACE = 8;
    localparam int unsigned HB_ENTER = 9;
    localparam int unsigned HB_ESC   = 10;

    function automatic logic is_ignored(input logic [CODE_W-1:0] b);
        return (b == SC_ERR0) || (b == SC_BAT)  || (b == SC_ECHO) || (b == SC_ACK) ||
               (b == SC_RSND) || (b == SC_ERR1) || (b == SC_E1);
    endfunction

    // One-hot held bit for a tracked key, zero for untracked keys.
    function automatic logic [HELD_W-1:0] held_mask(input logic ext, input logic [CODE_W-1:0] code);
        logic [HELD_W-1:0] m;
        m = '0;
        if (ext) begin
            case (code)
                SC_UP:    m[HB_UP]    = 1'b1;
                SC_DOWN:  m[HB_DOWN]  = 1'b1;
                SC_LEFT:  m[HB_LEFT]  = 1'b1;
                SC_RIGHT: m[HB_RIGHT] = 1'b1;
                default:  m = '0;
            endcase
        end else begin
            case (code)
                SC_W:     m[HB_W]     = 1'b1;
                SC_S:     m[HB_S]     = 1'b1;
                SC_A:     m[HB_A]     = 1'b1;
                SC_D:     m[HB_D]     = 1'b1;
                SC_SPACE: m[HB_SPACE] = 1'b1;
                SC_ENTER: m[HB_ENTER] = 1'b1;
                SC_ESC:   m[HB_ESC]   = 1'b1;
                default:  m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Receiver byte window in, decoded key events and held-key levels out.
interface ps2_key_decoder_if;
    import ps2_pkg::*;

    logic [WORD_W-1:0] xkey;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_ext;
    logic              key_break;
    logic [HELD_W-1:0] held;

    modport master (output xkey, input key_valid, key_code, key_ext, key_break, held);
    modport slave  (input xkey, output key_valid, key_code, key_ext, key_break, held);
endinterface

// File: rtl/ps2_word_settle.sv
// Synchronizes the PS/2 byte window into clk25 and strobes each newly settled word's low byte.
module ps2_word_settle
    import ps2_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4000
) (
    input  logic              clk25,
    input  logic              clr,
    input  logic [WORD_W-1:0] i_xkey,
    output logic              o_new_byte,
    output logic [CODE_W-1:0] o_byte
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WORD_W-1:0] r_sync1;
    logic [WORD_W-1:0] r_xs;
    logic [WORD_W-1:0] r_last_word;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_new_byte;
    logic [CODE_W-1:0] r_byte;

    logic w_change;
    logic w_accept;

    // Counter restarts on the same edge xs takes a new value, so it counts cycles xs has held.
    assign w_change = (r_sync1 != r_xs);
    assign w_accept = !w_change && (r_cnt == CNT_LAST);

    always_ff @(posedge clk25 or posedge clr) begin
        if (clr) begin
            r_sync1     <= '0;
            r_xs        <= '0;
            r_cnt       <= '0;
            r_last_word <= '0;
            r_new_byte  <= 1'b0;
            r_byte      <= '0;
        end else begin
            r_sync1    <= i_xkey;
            r_xs       <= r_sync1;
            r_new_byte <= 1'b0;
            if (w_change) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_accept && (r_xs != r_last_word)) begin
                r_new_byte  <= 1'b1;
                r_byte      <= r_xs[CODE_W-1:0];
                r_last_word <= r_xs;
            end
        end
    end

    assign o_new_byte = r_new_byte;
    assign o_byte     = r_byte;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: E0/F0 prefix tracking, key event registers and held-key vector.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4000
) (
    input  logic            clk25,
    input  logic            clr,
    ps2_key_decoder_if.slave kb
);

    logic              w_new_byte;
    logic [CODE_W-1:0] w_byte;

    ps2_word_settle #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_settle (
        .clk25      (clk25),
        .clr        (clr),
        .i_xkey     (kb.xkey),
        .o_new_byte (w_new_byte),
        .o_byte     (w_byte)
    );

    prefix_t           r_state;
    prefix_t           w_state_nxt;
    logic              w_emit;
    logic              w_emit_ext;
    logic              w_emit_brk;
    logic [HELD_W-1:0] w_mask;
    logic [HELD_W-1:0] w_held_nxt;

    logic              r_key_valid;
    logic [CODE_W-1:0] r_key_code;
    logic              r_key_ext;
    logic              r_key_break;
    logic [HELD_W-1:0] r_held;

    always_ff @(posedge clk25 or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Prefix next-state and event decode for the incoming byte.
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_emit_ext  = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
        w_emit_brk  = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
        if (w_new_byte) begin
            if (w_byte == SC_E0) begin
                w_state_nxt = ST_EXT;
            end else if (w_byte == SC_F0) begin
                case (r_state)
                    ST_IDLE: w_state_nxt = ST_BRK;
                    ST_EXT:  w_state_nxt = ST_EXT_BRK;
                    default: w_state_nxt = r_state;
                endcase
            end else if (is_ignored(w_byte)) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_emit      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        end
        w_mask     = held_mask(w_emit_ext, w_byte);
        w_held_nxt = r_held;
        if (w_emit) begin
            w_held_nxt = w_emit_brk ? (r_held & ~w_mask) : (r_held | w_mask);
        end
    end

    always_ff @(posedge clk25 or posedge clr) begin
        if (clr) begin
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_key_ext   <= 1'b0;
            r_key_break <= 1'b0;
            r_held      <= '0;
        end else begin
            r_key_valid <= w_emit;
            r_held      <= w_held_nxt;
            if (w_emit) begin
                r_key_code  <= w_byte;
                r_key_ext   <= w_emit_ext;
                r_key_break <= w_emit_brk;
            end
        end
    end

    assign kb.key_valid = r_key_valid;
    assign kb.key_code  = r_key_code;
    assign kb.key_ext   = r_key_ext;
    assign kb.key_break = r_key_break;
    assign kb.held      = r_held;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with a short settle period.
module tb_ps2_key_decoder;

    logic clk25;
    logic clr;

    ps2_key_decoder_if kb ();

    ps2_key_decoder #(
        .STABLE_CYCLES (8)
    ) dut (
        .clk25 (clk25),
        .clr   (clr),
        .kb    (kb)
    );

    int n_asserts;
    int n_fail;
    int nev;
    int lat;
    logic [7:0]  ev_code;
    logic        ev_ext;
    logic        ev_brk;
    logic [10:0] ev_held;

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a word at a negedge, then watch a bounded number of cycles for events.
    task automatic run_word(input logic [15:0] w, input int cycles);
        kb.xkey = w;
        nev = 0;
        lat = -1;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk25);
            if (kb.key_valid === 1'b1) begin
                nev++;
                if (lat < 0) lat = i;
                ev_code = kb.key_code;
                ev_ext  = kb.key_ext;
                ev_brk  = kb.key_break;
                ev_held = kb.held;
            end
        end
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        kb.xkey   = 16'h0000;
        clr       = 1'b1;
        repeat (3) @(negedge clk25);

        check("rst_valid", 32'(kb.key_valid), 32'h0);
        check("rst_code",  32'(kb.key_code),  32'h0);
        check("rst_ext",   32'(kb.key_ext),   32'h0);
        check("rst_break", 32'(kb.key_break), 32'h0);
        check("rst_held",  32'(kb.held),      32'h0);

        clr = 1'b0;
        run_word(16'h0000, 100);
        check("idle_events", 32'(nev), 32'd0);
        check("idle_held", 32'(kb.held), 32'h0);

        run_word(16'h001D, 30);
        check("w_make_events", 32'(nev), 32'd1);
        check("w_make_latency", 32'(lat), 32'd11);
        check("w_make_code", 32'(ev_code), 32'h1D);
        check("w_make_ext", 32'(ev_ext), 32'h0);
        check("w_make_break", 32'(ev_brk), 32'h0);
        check("w_make_held", 32'(ev_held), 32'h010);

        run_word(16'h1DF0, 20);
        check("f0_no_event", 32'(nev), 32'd0);
        run_word(16'hF01D, 20);
        check("w_break_events", 32'(nev), 32'd1);
        check("w_break_code", 32'(ev_code), 32'h1D);
        check("w_break_ext", 32'(ev_ext), 32'h0);
        check("w_break_break", 32'(ev_brk), 32'h1);
        check("w_break_held", 32'(ev_held), 32'h000);

        run_word(16'h1DE0, 20);
        check("e0_no_event", 32'(nev), 32'd0);
        run_word(16'hE075, 20);
        check("up_make_events", 32'(nev), 32'd1);
        check("up_make_code", 32'(ev_code), 32'h75);
        check("up_make_ext", 32'(ev_ext), 32'h1);
        check("up_make_break", 32'(ev_brk), 32'h0);
        check("up_make_held", 32'(ev_held), 32'h001);
        run_word(16'h75E0, 20);
        check("up_e0_no_event", 32'(nev), 32'd0);
        run_word(16'hE0F0, 20);
        check("up_f0_no_event", 32'(nev), 32'd0);
        run_word(16'hF075, 20);
        check("up_break_events", 32'(nev), 32'd1);
        check("up_break_code", 32'(ev_code), 32'h75);
        check("up_break_ext", 32'(ev_ext), 32'h1);
        check("up_break_break", 32'(ev_brk), 32'h1);
        check("up_break_held", 32'(ev_held), 32'h000);

        run_word(16'h0001, 5);
        check("glitch1_no_event", 32'(nev), 32'd0);
        run_word(16'h0003, 5);
        check("glitch3_no_event", 32'(nev), 32'd0);
        run_word(16'h0007, 5);
        check("glitch7_no_event", 32'(nev), 32'd0);
        run_word(16'h001C, 30);
        check("a_make_events", 32'(nev), 32'd1);
        check("a_make_code", 32'(ev_code), 32'h1C);
        check("a_make_break", 32'(ev_brk), 32'h0);
        check("a_make_held", 32'(ev_held), 32'h040);

        run_word(16'h00F0, 20);
        check("f0_again_no_event", 32'(nev), 32'd0);
        run_word(16'hF0AA, 20);
        check("aa_no_event", 32'(nev), 32'd0);
        run_word(16'hAA1B, 20);
        check("s_make_events", 32'(nev), 32'd1);
        check("s_make_code", 32'(ev_code), 32'h1B);
        check("s_make_break", 32'(ev_brk), 32'h0);
        check("s_make_held", 32'(ev_held), 32'h060);

        run_word(16'h1B29, 4);
        check("pending_no_event", 32'(nev), 32'd0);
        clr = 1'b1;
        repeat (2) @(negedge clk25);
        check("clr_held", 32'(kb.held), 32'h0);
        check("clr_valid", 32'(kb.key_valid), 32'h0);
        check("clr_code", 32'(kb.key_code), 32'h0);
        kb.xkey = 16'h0000;
        clr = 1'b0;
        run_word(16'h0000, 40);
        check("post_clr_no_event", 32'(nev), 32'd0);
        check("post_clr_held", 32'(kb.held), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Converts the raw 16-bit PS/2 byte window `xkey` (`{previous byte, latest byte}`, updated in the PS/2 clock domain) into clean, clk25-synchronous key events and a held-key vector for the game logic. It synchronizes `xkey` into clk25 and accepts a word only after it has been stable for a full settle period. It then runs a prefix state machine (E0 extended, F0 break) over the new low byte. It sits directly downstream of the PS/2 receiver and upstream of the game control FSM.

## Interface
- `STABLE_CYCLES`, default 4000: clk25 cycles `xkey` must stay unchanged before it is accepted. The default is 160 µs, longer than the slowest PS/2 bit period.
- `clk25` input, 1 bit: system clock, 25 MHz.
- `clr` input, 1 bit: reset, asynchronous, active-high.
- `xkey` input, 16 bits: receiver byte window. `[7:0]` is the latest byte and `[15:8]` the previous one. It is asynchronous to clk25.
- `key_valid` output, 1 bit: one-cycle event strobe.
- `key_code` output, 8 bits: scan code of the event, without prefixes.
- `key_ext` output, 1 bit: the event was preceded by E0.
- `key_break` output, 1 bit: the event is a release, because it was preceded by F0.
- `held` output, 11 bits: level per tracked key, 1 while the key is down.

## Operation
- Sync: each bit of `xkey` passes through 2 flops into `xs`.
- Settle counter:
  - It clears whenever `xs` differs from its previous-cycle value, and otherwise increments.
  - It saturates at `STABLE_CYCLES`.
  - An accept occurs exactly once, on the cycle the counter reaches `STABLE_CYCLES`.
- Word compare: on an accept, if `xs` differs from `last_word`, the block processes byte `b = xs[7:0]` and sets `last_word <= xs`. If `xs` equals `last_word`, nothing happens. As a result, identical typematic repeats (`{1D,1D}`) produce no events.
- Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen).
  - `b = E0`: IDLE → EXT. From any other state the next state is EXT, and the previous prefix is discarded.
  - `b = F0`: IDLE → BRK, EXT → EXT_BRK. BRK and EXT_BRK stay where they are.
  - `b` in {00, AA, EE, FA, FE, FF, E1}: ignored. No event fires and the FSM goes to IDLE.
  - Any other `b`: emit an event with `key_code = b`, `key_ext` = (state is EXT or EXT_BRK), and `key_break` = (state is BRK or EXT_BRK). Then the FSM goes to IDLE.
- Held mapping: on an event whose `(ext, code)` matches a bit, that bit is set to `!key_break`. Keys with no mapping emit an event and leave `held` unchanged.

| `held` bit | Key | ext | code |
|---|---|---|---|
| 0 | up | 1 | 75 |
| 1 | down | 1 | 72 |
| 2 | left | 1 | 6B |
| 3 | right | 1 | 74 |
| 4 | W | 0 | 1D |
| 5 | S | 0 | 1B |
| 6 | A | 0 | 1C |
| 7 | D | 0 | 23 |
| 8 | space | 0 | 29 |
| 9 | enter | 0 | 5A |
| 10 | esc | 0 | 76 |

- Set and clear are idempotent: a make for a key already held leaves it at 1, and a break for a key not held leaves it at 0.

## Timing
- Reset values:
  - Outputs: `key_valid` = 0, `key_code` = 00, `key_ext` = 0, `key_break` = 0, `held` = 0.
  - Internal: FSM in IDLE, counter = 0, `last_word` = 0000, sync flops = 0.
- Latency: `key_valid` is high on clk25 cycle 2 + `STABLE_CYCLES` + 1 after the last `xkey` transition. All outputs are registered.
- `key_code`, `key_ext` and `key_break` update with `key_valid` and hold until the next event.
- `held` updates on the same edge that asserts `key_valid`.
- A change in `xs` while the counter is below `STABLE_CYCLES` restarts the count. Intermediate shift values inside a PS/2 frame are never accepted.
- Reset mid-operation clears the prefix state and the counter immediately. A pending, not-yet-accepted word is lost.
- After `clr` is released with `xkey = 0000`, no event fires.

## Structure
- Package `ps2_pkg`:
  - Scan-code constants: E0, F0, the ignore set, and the 11 mapped codes.
  - Prefix FSM state enum.
  - `held` bit-index constants.
- Sub-module `ps2_word_settle`: 2-flop sync, settle counter, and the accept/compare logic. It outputs a one-cycle `new_byte` strobe and `byte[7:0]`.
- The top level holds the FSM, the event registers and `held`.

## Test plan
Run with `STABLE_CYCLES = 8`.
1. Reset with `xkey = 0000`, then release: all outputs are 0 and no `key_valid` occurs for 100 cycles.
2. Set `xkey` 0000 → 001D and hold: exactly one `key_valid` 11 cycles later, with `code` = 1D, `ext` = 0, `break` = 0, and `held[4]` = 1.
3. Set `xkey` 1DF0, then F01D, each held for 20 cycles: no event for F0. Then one event with `code` = 1D, `break` = 1, and `held[4]` = 0.
4. Send E0 75 (`xkey` 1DE0, E075), then E0 F0 75 (75E0, E0F0, F075):
   - The make gives `code` = 75, `ext` = 1, `break` = 0, and `held[0]` = 1.
   - The break gives `ext` = 1, `break` = 1, and `held[0]` = 0.
5. Drive `xkey` through 0001, 0003 and 0007 for 5 cycles each, then 001C held: exactly one event, with `code` = 1C, and `held[6]` = 1.
6. Send F0, then AA, then 1B (words 00F0, F0AA, AA1B): no event for AA. The 1B event has `break` = 0 and sets `held[5]` = 1. Pulse `clr` mid-count: `held` = 0 and no event.
